// File: rtl/output_drain_ctrl.sv
// ---------------------------------------------------------------------------
// output_drain_ctrl
//   Sequencer that sits directly upstream of output_block. On start_i it sweeps
//   every filter column presented on the PE array outputs: each group is
//   selected through the first-level muxes and captured into the o_regs. Each
//   captured word is then picked through the second-level mux and emitted on a
//   valid/ready stream, one word at a time, tagged with its array column.
//   Optional ReLU zeroes negative words.
//
//   Column mapping: group g of first-level mux k holds column c = k*G + g.
//   Emission order is therefore g-major: for each group, k = 0..M-1.
//   Columns c >= N_COLS_ARRAY are padding and are skipped without a FETCH/EMIT.
//
// Ports
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   start_i            1-cycle sweep request, only honoured in IDLE
//   n_groups_i         groups to sweep (0 = none, clamped to G), sampled with start
//   relu_en_i          zero negative words, sampled with start
//   data_in_i          output_block data_out_o (combinational from its o_regs)
//   sel_mux_out_1_o    first-level select: 0 = zero, g+1 = group g
//   sel_mux_out_2_o    second-level select (o_reg index k)
//   sel_mux_ld_o       load the selects in output_block
//   sel_mux_rst_o      output_block select reset (active-high)
//   reg_rst_o          output_block o_reg reset (active-high)
//   reg_wr_en_o        o_reg capture enable
//   out_data_o         result word
//   out_col_o          array column of out_data_o
//   out_valid_o        stream valid
//   out_last_o         final word of the sweep, qualified by out_valid_o
//   out_ready_i        stream ready
//   busy_o             high whenever the FSM is not IDLE
//   done_o             1-cycle pulse at end of sweep
// ---------------------------------------------------------------------------
module output_drain_ctrl #(
    parameter  int unsigned N_COLS_ARRAY           = 16,
    parameter  int unsigned I_WIDTH                = 8,
    parameter  int unsigned F_WIDTH                = 8,
    parameter  int unsigned NUMBER_MUX_OUT_1       = 4,
    localparam int unsigned W                      = I_WIDTH + F_WIDTH,
    localparam int unsigned NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1,
    localparam int unsigned SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1),
    localparam int unsigned SEL_WIDTH_MUX_OUT_2    = $clog2(NUMBER_MUX_OUT_1),
    localparam int unsigned COL_WIDTH              = $clog2(N_COLS_ARRAY)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic [SEL_WIDTH_MUX_OUT_1-1:0] n_groups_i,
    input  logic                           relu_en_i,
    input  logic [W-1:0]                   data_in_i,
    output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o,
    output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o,
    output logic                           sel_mux_ld_o,
    output logic                           sel_mux_rst_o,
    output logic                           reg_rst_o,
    output logic                           reg_wr_en_o,
    output logic [W-1:0]                   out_data_o,
    output logic [COL_WIDTH-1:0]           out_col_o,
    output logic                           out_valid_o,
    output logic                           out_last_o,
    input  logic                           out_ready_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned G      = NUMBER_INPUT_MUX_OUT_1;
    localparam int unsigned M      = NUMBER_MUX_OUT_1;
    localparam int unsigned SEL1_W = SEL_WIDTH_MUX_OUT_1;
    localparam int unsigned SEL2_W = SEL_WIDTH_MUX_OUT_2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL1  = 3'd1;
    localparam logic [2:0] S_CAPT  = 3'd2;
    localparam logic [2:0] S_SEL2  = 3'd3;
    localparam logic [2:0] S_FETCH = 3'd4;
    localparam logic [2:0] S_EMIT  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [SEL1_W-1:0] g_q, g_d;
    logic [SEL2_W-1:0] k_q, k_d;
    logic [SEL1_W-1:0] ng_q, ng_d;
    logic              relu_q, relu_d;

    logic [SEL1_W-1:0] sel1_d;
    logic [SEL2_W-1:0] sel2_d;
    logic              ld_d;
    logic              wr_d;
    logic [W-1:0]      data_d;
    logic [COL_WIDTH-1:0] col_d;
    logic              valid_d;
    logic              last_d;
    logic              done_d;
    logic              advance;

    logic [SEL1_W-1:0] ng_clamp;
    logic [31:0]       col_cur;
    logic [31:0]       col_next;
    logic              skip;
    logic              k_wrap;
    logic              g_last;
    logic              last_word;
    logic [W-1:0]      relu_data;

    // Requested group count limited to the groups output_block actually has
    assign ng_clamp = (n_groups_i > SEL1_W'(G)) ? SEL1_W'(G) : n_groups_i;

    // Column addressed by the current (g, k) and its successor within the group
    assign col_cur  = 32'(k_q) * 32'(G) + 32'(g_q);
    assign col_next = col_cur + 32'(G);
    assign skip     = (col_cur >= 32'(N_COLS_ARRAY));

    assign k_wrap   = (k_q == SEL2_W'(M - 1));
    assign g_last   = (g_q == (ng_q - SEL1_W'(1)));

    // Last word: final group, and no further non-padded column in this group
    assign last_word = g_last && (k_wrap || (col_next >= 32'(N_COLS_ARRAY)));

    assign relu_data = (relu_q && data_in_i[W-1]) ? '0 : data_in_i;

    // Next-state and next-output logic; outputs are registered so every value
    // set here is what output_block sees while the FSM sits in state_d.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        k_d     = k_q;
        ng_d    = ng_q;
        relu_d  = relu_q;
        sel1_d  = sel_mux_out_1_o;
        sel2_d  = sel_mux_out_2_o;
        ld_d    = 1'b0;
        wr_d    = 1'b0;
        data_d  = out_data_o;
        col_d   = out_col_o;
        valid_d = out_valid_o;
        last_d  = out_last_o;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ng_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ng_d    = ng_clamp;
                        relu_d  = relu_en_i;
                        g_d     = '0;
                        k_d     = '0;
                        sel1_d  = SEL1_W'(1);
                        sel2_d  = '0;
                        ld_d    = 1'b1;
                        state_d = S_SEL1;
                    end
                end
            end
            S_SEL1: begin
                wr_d    = 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                sel2_d  = k_q;
                ld_d    = 1'b1;
                state_d = S_SEL2;
            end
            S_SEL2: begin
                if (skip) begin
                    advance = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                data_d  = relu_data;
                col_d   = COL_WIDTH'(col_cur);
                valid_d = 1'b1;
                last_d  = last_word;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Step to the next o_reg, else the next group, else finish the sweep
        if (advance) begin
            if (!k_wrap) begin
                k_d     = k_q + SEL2_W'(1);
                sel2_d  = k_q + SEL2_W'(1);
                ld_d    = 1'b1;
                state_d = S_SEL2;
            end else if (!g_last) begin
                g_d     = g_q + SEL1_W'(1);
                k_d     = '0;
                sel1_d  = g_q + SEL1_W'(2);
                sel2_d  = '0;
                ld_d    = 1'b1;
                state_d = S_SEL1;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    // State and registered outputs; output_block resets stay high through reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= S_IDLE;
            g_q             <= '0;
            k_q             <= '0;
            ng_q            <= '0;
            relu_q          <= 1'b0;
            sel_mux_out_1_o <= '0;
            sel_mux_out_2_o <= '0;
            sel_mux_ld_o    <= 1'b0;
            sel_mux_rst_o   <= 1'b1;
            reg_rst_o       <= 1'b1;
            reg_wr_en_o     <= 1'b0;
            out_data_o      <= '0;
            out_col_o       <= '0;
            out_valid_o     <= 1'b0;
            out_last_o      <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            state_q         <= state_d;
            g_q             <= g_d;
            k_q             <= k_d;
            ng_q            <= ng_d;
            relu_q          <= relu_d;
            sel_mux_out_1_o <= sel1_d;
            sel_mux_out_2_o <= sel2_d;
            sel_mux_ld_o    <= ld_d;
            sel_mux_rst_o   <= 1'b0;
            reg_rst_o       <= 1'b0;
            reg_wr_en_o     <= wr_d;
            out_data_o      <= data_d;
            out_col_o       <= col_d;
            out_valid_o     <= valid_d;
            out_last_o      <= last_d;
            busy_o          <= (state_d != S_IDLE);
            done_o          <= done_d;
        end
    end

endmodule

// File: tb/tb_output_drain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_output_drain_ctrl
//   Directed bench for output_drain_ctrl. Two instances: dut_a with the default
//   16 columns and dut_b with 14 columns (padding columns 14, 15). A small
//   behavioural output_block per instance feeds data_in_i; column c holds
//   col_val[c] (100 + c unless a test overrides it).
// ---------------------------------------------------------------------------
module tb_output_drain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [2:0] n_groups;
    logic       relu_en;
    logic       ready;
    bit         sel;

    logic start_a, start_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;

    logic [2:0]  sel1_a, sel1_b;
    logic [1:0]  sel2_a, sel2_b;
    logic        ld_a, ld_b, srst_a, srst_b, rrst_a, rrst_b, wr_a, wr_b;
    logic [15:0] din_a, din_b, data_a, data_b;
    logic [3:0]  col_a, col_b;
    logic        valid_a, valid_b, last_a, last_b, busy_a, busy_b, done_a, done_b;

    output_drain_ctrl dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .n_groups_i(n_groups),
        .relu_en_i(relu_en), .data_in_i(din_a),
        .sel_mux_out_1_o(sel1_a), .sel_mux_out_2_o(sel2_a), .sel_mux_ld_o(ld_a),
        .sel_mux_rst_o(srst_a), .reg_rst_o(rrst_a), .reg_wr_en_o(wr_a),
        .out_data_o(data_a), .out_col_o(col_a), .out_valid_o(valid_a),
        .out_last_o(last_a), .out_ready_i(ready), .busy_o(busy_a), .done_o(done_a)
    );

    output_drain_ctrl #(.N_COLS_ARRAY(14)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .n_groups_i(n_groups),
        .relu_en_i(relu_en), .data_in_i(din_b),
        .sel_mux_out_1_o(sel1_b), .sel_mux_out_2_o(sel2_b), .sel_mux_ld_o(ld_b),
        .sel_mux_rst_o(srst_b), .reg_rst_o(rrst_b), .reg_wr_en_o(wr_b),
        .out_data_o(data_b), .out_col_o(col_b), .out_valid_o(valid_b),
        .out_last_o(last_b), .out_ready_i(ready), .busy_o(busy_b), .done_o(done_b)
    );

    // Behavioural output_block: selects latched on ld, o_regs captured on wr_en
    logic [15:0] col_val [16];
    logic [2:0]  s1l_a, s1l_b;
    logic [1:0]  s2l_a, s2l_b;
    logic [15:0] oreg_a [4];
    logic [15:0] oreg_b [4];

    function automatic logic [15:0] pick(input int k, input logic [2:0] s);
        if (s == 3'd0) return 16'h0;
        return col_val[k * 4 + int'(s) - 1];
    endfunction

    always @(posedge clk) begin
        if (srst_a) begin
            s1l_a <= 3'd0; s2l_a <= 2'd0;
        end else if (ld_a) begin
            s1l_a <= sel1_a; s2l_a <= sel2_a;
        end
        if (srst_b) begin
            s1l_b <= 3'd0; s2l_b <= 2'd0;
        end else if (ld_b) begin
            s1l_b <= sel1_b; s2l_b <= sel2_b;
        end
        for (int k = 0; k < 4; k++) begin
            if (rrst_a)    oreg_a[k] <= 16'h0;
            else if (wr_a) oreg_a[k] <= pick(k, s1l_a);
            if (rrst_b)    oreg_b[k] <= 16'h0;
            else if (wr_b) oreg_b[k] <= pick(k, s1l_b);
        end
    end

    assign din_a = oreg_a[s2l_a];
    assign din_b = oreg_b[s2l_b];

    // View of whichever instance the current test drives
    logic        v_valid, v_last, v_busy, v_done, v_srst, v_rrst;
    logic [15:0] v_data;
    logic [3:0]  v_col;
    always_comb begin
        v_valid = sel ? valid_b : valid_a;
        v_last  = sel ? last_b  : last_a;
        v_busy  = sel ? busy_b  : busy_a;
        v_done  = sel ? done_b  : done_a;
        v_srst  = sel ? srst_b  : srst_a;
        v_rrst  = sel ? rrst_b  : rrst_a;
        v_data  = sel ? data_b  : data_a;
        v_col   = sel ? col_b   : col_a;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected emission order; dut_b drops padding columns 14 and 15
    int exp16 [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    int exp14 [14] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 3, 7, 11};

    int q_col [$];
    int q_data [$];
    int q_last [$];
    int q_rel [$];
    int first_rel, done_rel, extra_done, post_valid;

    // Pulse start, then collect handshaked words with cycle stamps relative to
    // the edge that sampled start. Optional stall, mid-sweep restart pulse,
    // and early return when word stop_idx is presented.
    task automatic run_sweep(input int ng, input bit relu, input int stall_idx,
                             input int stall_len, input int restart_rel, input int stop_idx);
        int s;
        int rel;
        int stall_cnt;
        bit fin;
        q_col.delete(); q_data.delete(); q_last.delete(); q_rel.delete();
        first_rel = -1; done_rel = -1; extra_done = 0; post_valid = 0;
        stall_cnt = 0; fin = 1'b0;
        n_groups = 3'(ng); relu_en = relu; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start = 1'b0;
        for (int t = 0; t < 400 && !fin; t++) begin
            rel   = cyc - s;
            ready = 1'b1;
            if (v_valid && first_rel < 0) first_rel = rel;
            if (stop_idx >= 0 && v_valid && q_col.size() == stop_idx) begin
                ready = 1'b0;
                return;
            end
            if (v_valid && q_col.size() == stall_idx && stall_cnt < stall_len) begin
                ready = 1'b0;
                stall_cnt++;
                check("stall_col",  32'(v_col),  32'(exp16[stall_idx]));
                check("stall_data", 32'(v_data), 32'(100 + exp16[stall_idx]));
            end
            if (done_rel >= 0 && v_valid) post_valid++;
            if (v_valid && ready) begin
                q_col.push_back(int'(v_col));
                q_data.push_back(int'(v_data));
                q_last.push_back(int'(v_last));
                q_rel.push_back(rel);
            end
            if (v_done) begin
                if (done_rel < 0) done_rel = rel;
                else extra_done++;
            end
            start = (rel == restart_rel);
            if (done_rel >= 0 && rel >= done_rel + 6) fin = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check("sweep_finished", 32'(fin), 32'd1);
    endtask

    task automatic check_seq(input int n, input bit b14, input bit chk_data);
        check("n_words", 32'(q_col.size()), 32'(n));
        for (int i = 0; i < n && i < q_col.size(); i++) begin
            int c;
            if (b14) c = exp14[i];
            else     c = exp16[i];
            check($sformatf("col[%0d]", i), 32'(q_col[i]), 32'(c));
            if (chk_data) check($sformatf("data[%0d]", i), 32'(q_data[i]), 32'(100 + c));
            check($sformatf("last[%0d]", i), 32'(q_last[i]), 32'(i == n - 1));
        end
        check("extra_done", 32'(extra_done), 32'd0);
        check("valid_after_done", 32'(post_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 16; c++) col_val[c] = 16'(100 + c);
        sel = 1'b0; start = 1'b0; n_groups = 3'd0; relu_en = 1'b0; ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_sel_rst", 32'(v_srst),  32'd1);
        check("rst_reg_rst", 32'(v_rrst),  32'd1);
        check("rst_valid",   32'(v_valid), 32'd0);
        check("rst_busy",    32'(v_busy),  32'd0);
        check("rst_done",    32'(v_done),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_hold_after_release", 32'(v_srst), 32'd1);
        @(posedge clk); #1;
        check("rst_sel_rst_drop", 32'(v_srst), 32'd0);
        check("rst_reg_rst_drop", 32'(v_rrst), 32'd0);

        // 1: full sweep, ready high
        run_sweep(4, 1'b0, -1, 0, -1, -1);
        check_seq(16, 1'b0, 1'b1);
        check("t1_first_valid", 32'(first_rel), 32'd4);
        check("t1_word1_rel",   32'(q_rel[1]),  32'd7);
        check("t1_word4_rel",   32'(q_rel[4]),  32'd18);
        check("t1_last_rel",    32'(q_rel[15]), 32'd55);
        check("t1_done_rel",    32'(done_rel),  32'd56);
        check("t1_busy_idle",   32'(v_busy),    32'd0);

        // 2: backpressure on word 3 for 7 cycles
        run_sweep(4, 1'b0, 3, 7, -1, -1);
        check_seq(16, 1'b0, 1'b1);
        check("t2_word3_rel", 32'(q_rel[3]), 32'd20);
        check("t2_done_rel",  32'(done_rel), 32'd63);

        // 3: 14 columns; last is col 11 (final non-padded column of group 3)
        sel = 1'b1;
        run_sweep(4, 1'b0, -1, 0, -1, -1);
        check_seq(14, 1'b1, 1'b1);
        check("t3_last_rel", 32'(q_rel[13]), 32'd50);
        check("t3_done_rel", 32'(done_rel),  32'd52);
        sel = 1'b0;

        // 4: ReLU on and off
        col_val[2] = 16'hFFFB;
        col_val[3] = 16'h7FFF;
        run_sweep(4, 1'b1, -1, 0, -1, -1);
        check_seq(16, 1'b0, 1'b0);
        check("t4_relu_neg",  32'(q_data[8]),  32'h0);
        check("t4_relu_max",  32'(q_data[12]), 32'h7FFF);
        check("t4_relu_pos",  32'(q_data[0]),  32'd100);
        run_sweep(4, 1'b0, -1, 0, -1, -1);
        check("t4_norelu_neg", 32'(q_data[8]), 32'hFFFB);
        col_val[2] = 16'd102;
        col_val[3] = 16'd103;

        // 5: zero groups, then clamped group count
        run_sweep(0, 1'b0, -1, 0, -1, -1);
        check("t5_zero_done_rel",  32'(done_rel),   32'd0);
        check("t5_zero_no_valid",  32'(first_rel),  32'hFFFF_FFFF);
        check("t5_zero_done_once", 32'(extra_done), 32'd0);
        run_sweep(7, 1'b0, -1, 0, -1, -1);
        check_seq(16, 1'b0, 1'b1);
        check("t5_clamp_done_rel", 32'(done_rel), 32'd56);

        // 6: reset while word 5 is held in EMIT, then a clean sweep
        run_sweep(4, 1'b0, -1, 0, -1, 5);
        check("t6_stop_col",   32'(v_col),   32'd5);
        check("t6_stop_valid", 32'(v_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",   32'(v_valid), 32'd0);
        check("t6_rst_sel_rst", 32'(v_srst),  32'd1);
        check("t6_rst_reg_rst", 32'(v_rrst),  32'd1);
        check("t6_rst_busy",    32'(v_busy),  32'd0);
        check("t6_rst_done",    32'(v_done),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_rel_sel_rst", 32'(v_srst), 32'd0);
        run_sweep(4, 1'b0, -1, 0, 20, -1);
        check_seq(16, 1'b0, 1'b1);
        check("t6_done_rel", 32'(done_rel), 32'd56);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
